// File: rtl/lk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lk_pkg : shared types and widths for the Lucas-Kanade tensor stage  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lk_pkg;

  localparam int DATA_W    = 32;
  localparam int PROD_W    = 64;
  localparam int ACC_W_DEF = 64;
  localparam int NUM_LANES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index counter width; a single-element window still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lk_mac_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lk_mac_lane : signed 32x32 multiply-accumulate lane                 |
// | LK_TENSOR_SAT_EN selects saturating accumulate with sticky ovf.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lk_mac_lane
  import lk_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     ovf
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  addend;

  assign prod   = PROD_W'(a) * PROD_W'(b);
  assign addend = ACC_W'(prod);

`ifdef LK_TENSOR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_w;
  logic                  pos_ovf;
  logic                  neg_ovf;

  // One guard bit: the top two bits disagree exactly when the add overflowed.
  assign sum_w   = (ACC_W+1)'(acc) + (ACC_W+1)'(addend);
  assign pos_ovf = (sum_w[ACC_W:ACC_W-1] == 2'b01);
  assign neg_ovf = (sum_w[ACC_W:ACC_W-1] == 2'b10);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (pos_ovf) begin
        acc <= SAT_MAX;
        ovf <= 1'b1;
      end else if (neg_ovf) begin
        acc <= SAT_MIN;
        ovf <= 1'b1;
      end else begin
        acc <= sum_w[ACC_W-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + addend;
    end
  end

  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/lk_tensor_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lk_tensor_accum : serial structure-tensor accumulator (Sxx..Syt)    |
// | LK_TENSOR_SAT_EN enables saturating lanes and the ovf flag.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lk_tensor_accum
  import lk_pkg::*;
#(
  parameter int side  = 3,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic signed [DATA_W-1:0] Ix [0:side*side-1],
  input  logic signed [DATA_W-1:0] Iy [0:side*side-1],
  input  logic signed [DATA_W-1:0] It [0:side*side-1],
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic signed [ACC_W-1:0]  sxx,
  output logic signed [ACC_W-1:0]  sxy,
  output logic signed [ACC_W-1:0]  syy,
  output logic signed [ACC_W-1:0]  sxt,
  output logic signed [ACC_W-1:0]  syt,
  output logic                     ovf
);

  localparam int N     = side * side;
  localparam int IDX_W = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] ix_buf [0:N-1];
  logic signed [DATA_W-1:0] iy_buf [0:N-1];
  logic signed [DATA_W-1:0] it_buf [0:N-1];

  logic                     accept;
  logic                     lane_en;
  logic signed [DATA_W-1:0] cur_x;
  logic signed [DATA_W-1:0] cur_y;
  logic signed [DATA_W-1:0] cur_t;
  logic signed [DATA_W-1:0] lane_a [NUM_LANES];
  logic signed [DATA_W-1:0] lane_b [NUM_LANES];
  logic signed [ACC_W-1:0]  sums   [NUM_LANES];
  logic [NUM_LANES-1:0]     lane_ovf;

  // in_rdy is registered and only high in IDLE, so this is the acceptance.
  assign accept  = in_val && in_rdy;
  assign lane_en = (state == ACCUM);

  always_ff @(posedge clk) begin
    if (accept) begin
      ix_buf <= Ix;
      iy_buf <= Iy;
      it_buf <= It;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      in_rdy  <= 1'b1;
      out_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            state  <= ACCUM;
            idx    <= '0;
            in_rdy <= 1'b0;
          end
        end
        ACCUM: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state   <= DONE;
            out_val <= 1'b1;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state   <= IDLE;
            out_val <= 1'b0;
            in_rdy  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          in_rdy  <= 1'b1;
          out_val <= 1'b0;
        end
      endcase
    end
  end

  assign cur_x = ix_buf[idx];
  assign cur_y = iy_buf[idx];
  assign cur_t = it_buf[idx];

  // Lane order: xx, xy, yy, xt, yt.
  assign lane_a = '{cur_x, cur_x, cur_y, cur_x, cur_y};
  assign lane_b = '{cur_x, cur_y, cur_y, cur_t, cur_t};

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lk_mac_lane #(
        .ACC_W(ACC_W)
      ) u_lane (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .en   (lane_en),
        .a    (lane_a[g]),
        .b    (lane_b[g]),
        .acc  (sums[g]),
        .ovf  (lane_ovf[g])
      );
    end
  endgenerate

  assign sxx = sums[0];
  assign sxy = sums[1];
  assign syy = sums[2];
  assign sxt = sums[3];
  assign syt = sums[4];
  assign ovf = |lane_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lk_tensor_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lk_tensor_accum : scoreboard bench for lk_tensor_accum           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lk_tensor_accum;

  localparam int SIDE  = 3;
  localparam int N     = SIDE * SIDE;
  localparam int ACC_W = 64;

  typedef struct {
    logic signed [63:0] sxx;
    logic signed [63:0] sxy;
    logic signed [63:0] syy;
    logic signed [63:0] sxt;
    logic signed [63:0] syt;
    logic               ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic in_val;
  logic in_rdy;
  logic out_val;
  logic out_rdy;
  logic ovf;
  logic signed [31:0] Ix [0:N-1];
  logic signed [31:0] Iy [0:N-1];
  logic signed [31:0] It [0:N-1];
  logic signed [ACC_W-1:0] sxx, sxy, syy, sxt, syt;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = -1;
  int accept_cyc = 0;

  lk_tensor_accum #(
    .side (SIDE),
    .ACC_W(ACC_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .Ix     (Ix),
    .Iy     (Iy),
    .It     (It),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .sxx    (sxx),
    .sxy    (sxy),
    .syy    (syy),
    .sxt    (sxt),
    .syt    (syt),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic signed [63:0] a, b, c, d, e, input logic o);
    exp_t r;
    r.sxx = a; r.sxy = b; r.syy = c; r.sxt = d; r.syt = e; r.ovf = o;
    return r;
  endfunction

  task automatic fill_const(input logic signed [31:0] x, y, t);
    for (int k = 0; k < N; k++) begin
      Ix[k] = x; Iy[k] = y; It[k] = t;
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) begin
      Ix[k] = k; Iy[k] = 1; It[k] = -1;
    end
  endtask

  // Raise in_val, wait (bounded) for the acceptance edge, log the expectation.
  task automatic issue(input exp_t e, input bit push, input bit keep);
    int n = 0;
    in_val = 1'b1;
    @(negedge clk);
    while (!in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {63'b0, in_rdy}, 64'd1);
    accept_cyc = cyc;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) in_val = 1'b0;
  endtask

  task automatic check_latency();
    int n = 0;
    @(negedge clk);
    while (!out_val && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(cyc - accept_cyc), 64'(N + 1));
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_val && out_rdy) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sxx %h required no output", sxx);
        end else begin
          e = exp_q.pop_front();
          chk("sxx", sxx, e.sxx);
          chk("sxy", sxy, e.sxy);
          chk("syy", syy, e.syy);
          chk("sxt", sxt, e.sxt);
          chk("syt", syt, e.syt);
          chk("ovf", {63'b0, ovf}, {63'b0, e.ovf});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t nine;
    exp_t sat_e;
    int n;
    nine = mk(9, 9, 9, -9, -9, 1'b0);
    reset = 1'b1;
    in_val = 1'b0;
    out_rdy = 1'b1;
    fill_const(0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_in_rdy", {63'b0, in_rdy}, 64'd1);
    chk("rst_out_val", {63'b0, out_val}, 64'd0);
    chk("rst_sxx", sxx, 64'd0);
    chk("rst_syt", syt, 64'd0);
    chk("rst_ovf", {63'b0, ovf}, 64'd0);
    @(posedge clk);
    #1;

    // Basic all-ones window
    fill_const(1, 1, -1);
    issue(nine, 1'b1, 1'b0);
    check_latency();

    // Ramp window under backpressure
    out_rdy = 1'b0;
    fill_ramp();
    issue(mk(204, 36, 9, -36, -9, 1'b0), 1'b1, 1'b0);
    check_latency();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_val", {63'b0, out_val}, 64'd1);
      chk("bp_in_rdy", {63'b0, in_rdy}, 64'd0);
      chk("bp_sxx", sxx, 64'd204);
      chk("bp_sxt", sxt, -64'sd36);
    end
    @(posedge clk);
    #1 out_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_rdy", {63'b0, in_rdy}, 64'd1);
    chk("bp_release_out_val", {63'b0, out_val}, 64'd0);
    @(posedge clk);
    #1;

    // Reset while idx==4 discards the window
    fill_const(5, 5, 5);
    issue(nine, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_sxx", sxx, 64'd0);
    chk("mid_rst_syy", syy, 64'd0);
    chk("mid_rst_syt", syt, 64'd0);
    chk("mid_rst_in_rdy", {63'b0, in_rdy}, 64'd1);
    chk("mid_rst_out_val", {63'b0, out_val}, 64'd0);
    @(posedge clk);
    #1;
    fill_const(1, 1, -1);
    issue(nine, 1'b1, 1'b0);
    check_latency();

    // Back-to-back with in_val held high
    fill_ramp();
    issue(mk(204, 36, 9, -36, -9, 1'b0), 1'b1, 1'b1);
    fill_const(2, -3, 5);
    check_latency();
    issue(mk(36, -54, 81, 90, -135, 1'b0), 1'b1, 1'b0);
    chk("b2b_gap", 64'(accept_cyc - hs_cyc), 64'd1);
    check_latency();

    // Large operands: saturate or wrap depending on the build
    fill_const(32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 0);
`ifdef LK_TENSOR_SAT_EN
    sat_e = mk(64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF,
               64'sh7FFF_FFFF_FFFF_FFFF, 0, 0, 1'b1);
`else
    sat_e = mk(64'sh3FFF_FFF7_0000_0009, 64'sh3FFF_FFF7_0000_0009,
               64'sh3FFF_FFF7_0000_0009, 0, 0, 1'b0);
`endif
    issue(sat_e, 1'b1, 1'b0);
    check_latency();

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
